// File: rtl/uart_ram_loader.sv
// uart_ram_loader: serial program loader for the 256x8 program/video RAM.
//
// Receives 8N1 UART bytes on rx and frames them as a load packet:
//   SYNC_BYTE, N (0 means 256), N data bytes [, checksum byte]
// The payload is written to RAM starting at address 0. While a packet is in
// flight, and after any aborted packet, cpu_hold keeps the CPU in reset and
// gives this block ownership of the RAM write port. Only a successful packet
// releases cpu_hold.
//
// Optional feature: define UART_LOADER_CHECKSUM_EN to expect a trailing
// checksum byte (8-bit sum of N and all data bytes). On a checksum mismatch
// the packet ends with err=1 and cpu_hold left high.
//
// Ports:
//   CLOCK_50   in   system clock
//   reset      in   asynchronous, active-high reset
//   rx         in   UART receive line, idle high, asynchronous to CLOCK_50
//   mem_we     out  one-cycle RAM write strobe
//   mem_addr   out  RAM write address
//   mem_wdata  out  RAM write data
//   cpu_hold   out  1 = CPU held in reset, RAM port owned by the loader
//   done       out  sticky, last packet completed successfully
//   err        out  sticky, last packet aborted
module uart_ram_loader #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       rx,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       done,
    output logic       err
);

    localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] DivM1 = CW'(DIV - 1);
    localparam logic [CW-1:0] Half  = CW'(DIV / 2);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [1:0] {
        PIdle, PCount, PData
`ifdef UART_LOADER_CHECKSUM_EN
        , PChk
`endif
    } p_state_e;

    // ---------------- rx synchroniser ----------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ---------------- byte receiver ----------------
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_valid, frame_err;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rx_state_q <= RxIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RxStart;
                    cnt_d      = Half;
                end
            end
            RxStart: begin
                if (cnt_q == '0) begin
                    // Line back high at mid start bit: treat as a glitch.
                    if (rx_sync_q) begin
                        rx_state_d = RxIdle;
                    end else begin
                        rx_state_d = RxData;
                        cnt_d      = DivM1;
                        bit_idx_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RxData: begin
                if (cnt_q == '0) begin
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    cnt_d     = DivM1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) rx_state_d = RxStop;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RxStop: begin
                if (cnt_q == '0) begin
                    rx_state_d = RxIdle;
                    byte_valid = rx_sync_q;
                    frame_err  = !rx_sync_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ---------------- packet framer ----------------
    p_state_e   p_state_q, p_state_d;
    logic [8:0] rem_q, rem_d;
    logic       mem_we_q, mem_we_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;
    logic       cpu_hold_q, cpu_hold_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] sum_q, sum_d;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            p_state_q   <= PIdle;
            rem_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sum_q       <= '0;
        end else begin
            p_state_q   <= p_state_d;
            rem_q       <= rem_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
            sum_q       <= sum_d;
        end
    end

    always_comb begin
        p_state_d   = p_state_q;
        rem_d       = rem_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        err_d       = err_q;
        sum_d       = sum_q;

        unique case (p_state_q)
            PIdle: begin
                if (byte_valid && shift_q == SYNC_BYTE) begin
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    mem_addr_d = '0;
                    p_state_d  = PCount;
                end
            end
            PCount: begin
                if (byte_valid) begin
                    rem_d     = (shift_q == 8'd0) ? 9'd256 : {1'b0, shift_q};
                    sum_d     = shift_q;
                    p_state_d = PData;
                end
            end
            PData: begin
                if (byte_valid) begin
                    mem_wdata_d = shift_q;
                    mem_we_d    = 1'b1;
                    sum_d       = sum_q + shift_q;
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            PChk: begin
                if (byte_valid) begin
                    p_state_d = PIdle;
                    if (shift_q == sum_q) begin
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
`endif
            default: p_state_d = PIdle;
        endcase

        // Aborted packets leave cpu_hold set so a partial image never runs.
        if (frame_err && p_state_q != PIdle) begin
            err_d     = 1'b1;
            mem_we_d  = 1'b0;
            p_state_d = PIdle;
        end

        // Post-write bookkeeping happens in the cycle the strobe is visible.
        if (mem_we_q) begin
            mem_addr_d = mem_addr_q + 8'd1;
            rem_d      = rem_q - 9'd1;
            if (rem_q == 9'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
                p_state_d  = PChk;
`else
                p_state_d  = PIdle;
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
`endif
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Testbench for uart_ram_loader. A fast baud rate keeps DIV small so the
// 256-byte packet stays short. Expected RAM writes come from the packet
// contents: data byte i goes to address i mod 256.
module tb_uart_ram_loader;

    localparam int unsigned CLK_HZ = 50000000;
    localparam int unsigned BAUD   = 5000000;
    localparam int unsigned DIV    = (CLK_HZ + BAUD / 2) / BAUD;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       err;

    always #10 clk = ~clk;

    uart_ram_loader #(
        .CLK_HZ   (CLK_HZ),
        .BAUD     (BAUD),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .rx       (rx),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Write monitor: logs every strobe and flags strobes that are wider than
    // one cycle or occur while the CPU is not held.
    int         cyc = 0;
    logic [7:0] wr_addr[$];
    logic [7:0] wr_data[$];
    logic [7:0] ram[256];
    int         last_we_cyc = -1;
    int         hold_fall_cyc = -1;
    int         we_viol = 0;
    logic       we_prev = 1'b0;
    logic       hold_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            ram[mem_addr] = mem_wdata;
            last_we_cyc = cyc;
            if (cpu_hold !== 1'b1 || we_prev === 1'b1) we_viol++;
        end
        if (hold_prev === 1'b1 && cpu_hold === 1'b0) hold_fall_cyc = cyc;
        we_prev   = mem_we;
        hold_prev = cpu_hold;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] pkt_q[$];

    task automatic idle_bits(input int bits);
        repeat (bits * DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = good_stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
    endtask

    // Sends SYNC, N, pkt_q contents (and checksum when compiled in).
    task automatic send_packet(input bit bad_chk);
        logic [7:0] sum;
        sum = 8'(pkt_q.size());
        send_byte(8'hA5, 1'b1);
        idle_bits($urandom_range(0, 2));
        send_byte(8'(pkt_q.size()), 1'b1);
        foreach (pkt_q[i]) begin
            idle_bits($urandom_range(0, 2));
            send_byte(pkt_q[i], 1'b1);
            sum = sum + pkt_q[i];
        end
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(bad_chk ? sum + 8'd1 : sum, 1'b1);
`else
        if (bad_chk) sum = 8'd0;
`endif
        idle_bits(2);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b exp 0", mem_we); end
        n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h exp 00", mem_addr); end
        n_cmp++; if (mem_wdata !== 8'h00) begin n_bad++; $display("FAIL reset_wdata: got %h exp 00", mem_wdata); end
        n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL reset_hold: got %b exp 0", cpu_hold); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b exp 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b exp 0", err); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_d[3];
        exp_d = '{8'h11, 8'h22, 8'h33};
        clear_log();
        send_byte(8'hA5, 1'b1);
        n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL basic_hold_rise: got %b exp 1", cpu_hold); end
        pkt_q = '{8'h11, 8'h22, 8'h33};
        send_byte(8'h03, 1'b1);
        foreach (pkt_q[i]) send_byte(pkt_q[i], 1'b1);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(8'h03 + 8'h11 + 8'h22 + 8'h33, 1'b1);
`endif
        idle_bits(2);
        n_cmp++; if (wr_addr.size() != 3) begin n_bad++; $display("FAIL basic_count: got %0d exp 3", wr_addr.size()); end
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            n_cmp++;
            if (wr_addr[i] !== 8'(i) || wr_data[i] !== exp_d[i]) begin
                n_bad++;
                $display("FAIL basic_wr%0d: got %h@%h exp %h@%h", i, wr_data[i], wr_addr[i], exp_d[i], 8'(i));
            end
        end
        n_cmp++; if (done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0) begin n_bad++; $display("FAIL basic_flags: got done=%b err=%b hold=%b exp 1 0 0", done, err, cpu_hold); end
        n_cmp++; if (mem_addr !== 8'h03) begin n_bad++; $display("FAIL basic_addr: got %h exp 03", mem_addr); end
`ifndef UART_LOADER_CHECKSUM_EN
        n_cmp++; if (hold_fall_cyc != last_we_cyc + 1) begin n_bad++; $display("FAIL basic_hold_fall: got cycle %0d exp %0d", hold_fall_cyc, last_we_cyc + 1); end
`endif
        n_cmp++; if (we_viol != 0) begin n_bad++; $display("FAIL basic_we_shape: got %0d bad strobes exp 0", we_viol); end
    endtask

    task automatic test_junk_prefix();
        logic [7:0] a, b;
        a = 8'($urandom); b = 8'($urandom);
        clear_log();
        send_byte(8'h3C, 1'b1);
        send_byte(8'h5A, 1'b1);
        pkt_q = '{a, b};
        send_packet(1'b0);
        n_cmp++; if (wr_addr.size() != 2) begin n_bad++; $display("FAIL junk_count: got %0d exp 2", wr_addr.size()); end
        if (wr_addr.size() == 2) begin
            n_cmp++; if (wr_addr[0] !== 8'h00 || wr_data[0] !== a) begin n_bad++; $display("FAIL junk_wr0: got %h@%h exp %h@00", wr_data[0], wr_addr[0], a); end
            n_cmp++; if (wr_addr[1] !== 8'h01 || wr_data[1] !== b) begin n_bad++; $display("FAIL junk_wr1: got %h@%h exp %h@01", wr_data[1], wr_addr[1], b); end
        end
        n_cmp++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin n_bad++; $display("FAIL junk_flags: got done=%b hold=%b exp 1 0", done, cpu_hold); end
    endtask

    task automatic test_full_256();
        int bad;
        for (int i = 0; i < 256; i++) ram[i] = ~8'(i);
        clear_log();
        pkt_q.delete();
        for (int i = 0; i < 256; i++) pkt_q.push_back(8'(i));
        send_packet(1'b0);
        n_cmp++; if (wr_addr.size() != 256) begin n_bad++; $display("FAIL full_count: got %0d exp 256", wr_addr.size()); end
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            n_cmp++;
            if (ram[i] !== 8'(i)) begin
                n_bad++;
                if (bad < 4) $display("FAIL full_ram[%0d]: got %h exp %h", i, ram[i], 8'(i));
                bad++;
            end
        end
        n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL full_addr_wrap: got %h exp 00", mem_addr); end
        n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL full_flags: got done=%b err=%b exp 1 0", done, err); end
    endtask

    task automatic test_frame_err();
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b0);
        idle_bits(2);
        n_cmp++; if (err !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL ferr_flags: got err=%b done=%b exp 1 0", err, done); end
        n_cmp++; if (wr_addr.size() != 2) begin n_bad++; $display("FAIL ferr_count: got %0d exp 2", wr_addr.size()); end
        n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL ferr_hold: got %b exp 1", cpu_hold); end
        // A stray byte after an abort must not be taken as data.
        send_byte(8'h55, 1'b1);
        idle_bits(1);
        n_cmp++; if (wr_addr.size() != 2) begin n_bad++; $display("FAIL ferr_idle_byte: got %0d writes exp 2", wr_addr.size()); end
        clear_log();
        pkt_q = '{8'h7E};
        send_packet(1'b0);
        n_cmp++; if (wr_addr.size() != 1) begin n_bad++; $display("FAIL recover_count: got %0d exp 1", wr_addr.size()); end
        if (wr_addr.size() == 1) begin
            n_cmp++; if (wr_addr[0] !== 8'h00 || wr_data[0] !== 8'h7E) begin n_bad++; $display("FAIL recover_wr: got %h@%h exp 7e@00", wr_data[0], wr_addr[0]); end
        end
        n_cmp++; if (cpu_hold !== 1'b0 || err !== 1'b0 || done !== 1'b1) begin n_bad++; $display("FAIL recover_flags: got hold=%b err=%b done=%b exp 0 0 1", cpu_hold, err, done); end
    endtask

    task automatic test_glitch_reset();
        logic [7:0] a;
        clear_log();
        idle_bits(1);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        idle_bits(3);
        n_cmp++; if (wr_addr.size() != 0 || done !== 1'b1 || cpu_hold !== 1'b0) begin n_bad++; $display("FAIL glitch: got writes=%0d done=%b hold=%b exp 0 1 0", wr_addr.size(), done, cpu_hold); end
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h10, 1'b1);
        fork
            send_byte(8'h20, 1'b1);
            begin
                repeat (40) @(negedge clk);
                #3 reset = 1'b1;
                #1;
                n_cmp++; if (cpu_hold !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL async_reset_flags: got hold=%b we=%b done=%b err=%b exp 0 0 0 0", cpu_hold, mem_we, done, err); end
                n_cmp++; if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin n_bad++; $display("FAIL async_reset_bus: got %h@%h exp 00@00", mem_wdata, mem_addr); end
            end
        join
        idle_bits(1);
        #3 reset = 1'b0;
        n_cmp++; if (wr_addr.size() != 1 || ram[0] !== 8'h10) begin n_bad++; $display("FAIL pre_reset_write: got writes=%0d ram0=%h exp 1 10", wr_addr.size(), ram[0]); end
        clear_log();
        a = 8'($urandom);
        pkt_q = '{a, 8'hA5};
        send_packet(1'b0);
        n_cmp++; if (wr_addr.size() != 2 || ram[0] !== a || ram[1] !== 8'hA5) begin n_bad++; $display("FAIL post_reset_pkt: got writes=%0d %h %h exp 2 %h a5", wr_addr.size(), ram[0], ram[1], a); end
        n_cmp++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin n_bad++; $display("FAIL post_reset_flags: got done=%b hold=%b exp 1 0", done, cpu_hold); end
    endtask

    task automatic test_random_packets();
        int n;
        logic [7:0] j;
        for (int p = 0; p < 6; p++) begin
            clear_log();
            j = 8'($urandom);
            if (j == 8'hA5) j = 8'h3C;
            send_byte(j, 1'b1);
            n = $urandom_range(1, 12);
            pkt_q.delete();
            for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
            send_packet(1'b0);
            n_cmp++; if (wr_addr.size() != n) begin n_bad++; $display("FAIL rnd%0d_count: got %0d exp %0d", p, wr_addr.size(), n); end
            for (int i = 0; i < n && i < wr_addr.size(); i++) begin
                n_cmp++;
                if (wr_addr[i] !== 8'(i) || wr_data[i] !== pkt_q[i]) begin
                    n_bad++;
                    $display("FAIL rnd%0d_wr%0d: got %h@%h exp %h@%h", p, i, wr_data[i], wr_addr[i], pkt_q[i], 8'(i));
                end
            end
            n_cmp++; if (done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0 || mem_addr !== 8'(n)) begin n_bad++; $display("FAIL rnd%0d_end: got done=%b err=%b hold=%b addr=%h exp 1 0 0 %h", p, done, err, cpu_hold, mem_addr, 8'(n)); end
`ifndef UART_LOADER_CHECKSUM_EN
            n_cmp++; if (hold_fall_cyc != last_we_cyc + 1) begin n_bad++; $display("FAIL rnd%0d_hold_fall: got cycle %0d exp %0d", p, hold_fall_cyc, last_we_cyc + 1); end
`endif
        end
    endtask

`ifdef UART_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        clear_log();
        pkt_q = '{8'h10, 8'h20};
        send_packet(1'b0);
        n_cmp++; if (done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0) begin n_bad++; $display("FAIL chk_good: got done=%b err=%b hold=%b exp 1 0 0", done, err, cpu_hold); end
        clear_log();
        send_packet(1'b1);
        n_cmp++; if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin n_bad++; $display("FAIL chk_bad: got err=%b done=%b hold=%b exp 1 0 1", err, done, cpu_hold); end
        n_cmp++; if (wr_addr.size() != 2) begin n_bad++; $display("FAIL chk_bad_writes: got %0d exp 2", wr_addr.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_junk_prefix();
        test_full_256();
        test_frame_err();
        test_glitch_reset();
        test_random_packets();
`ifdef UART_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        n_cmp++; if (we_viol != 0) begin n_bad++; $display("FAIL we_shape_total: got %0d bad strobes exp 0", we_viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
